// File: rtl/ring_ro_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ro_sched_if
//  Description : Bus bundle between the ring readout scheduler, the lockstep
//                ring buffer RAMs and the downstream sample consumer.
//                  wr_en_o / wr_addr_o      shared write strobe and address
//                  rd_en_o / rd_addr_o      read strobe and address
//                  ch_sel_o                 channel select for the mem_q_i mux
//                  mem_q_i                  selected read data (1 cycle late)
//                  dout_o / dout_ch_o       output sample and its channel
//                  dout_valid_o / dout_ready_i / dout_last_o  stream handshake
//                master = scheduler side, slave = RAM/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ring_ro_sched_if #(
   parameter int SIZE = 8,
   parameter int DW   = 12,
   parameter int CHW  = 2
);
   logic            wr_en_o;
   logic [SIZE-1:0] wr_addr_o;
   logic            rd_en_o;
   logic [SIZE-1:0] rd_addr_o;
   logic [CHW-1:0]  ch_sel_o;
   logic [DW-1:0]   mem_q_i;
   logic [DW-1:0]   dout_o;
   logic [CHW-1:0]  dout_ch_o;
   logic            dout_valid_o;
   logic            dout_ready_i;
   logic            dout_last_o;

   modport master (
      output wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, ch_sel_o,
      input  mem_q_i,
      output dout_o, dout_ch_o, dout_valid_o, dout_last_o,
      input  dout_ready_i
   );

   modport slave (
      input  wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, ch_sel_o,
      output mem_q_i,
      input  dout_o, dout_ch_o, dout_valid_o, dout_last_o,
      output dout_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/ring_ro_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ro_sched
//  Description : Acquisition / readout sequencer for NCH lockstep ring
//                buffers. Writes continuously while armed, runs a
//                post-trigger window, freezes writes, then reads `howmany`
//                samples per channel (channel 0 first) into a 2-deep skid
//                buffer feeding a valid/ready stream.
//  Ports       : clk, rst_n (sync, active low)
//                arm_i, trig_i, posttrig_i, offset_i, howmany_i  control
//                bus (ring_ro_sched_if.master)  RAM and output stream
//                busy_o, done_o, trig_lost_o                     status
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_ro_sched #(
   parameter int SIZE = 8,
   parameter int DW   = 12,
   parameter int NCH  = 4,
   parameter int CHW  = 2
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            arm_i,
   input  wire logic            trig_i,
   input  wire logic [SIZE-1:0] posttrig_i,
   input  wire logic [SIZE-1:0] offset_i,
   input  wire logic [SIZE-1:0] howmany_i,
   ring_ro_sched_if.master      bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 trig_lost_o
);

   localparam logic [CHW-1:0] c_LAST_CH = CHW'(NCH - 1);
   localparam int             c_SKW     = DW + CHW + 1;   // {last, ch, data}

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACQ   = 3'd1,
      S_POST  = 3'd2,
      S_READ  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t           r_state, w_state_nxt;

   logic [SIZE-1:0]  r_wr_addr;
   logic [SIZE-1:0]  r_post_cnt;
   logic [SIZE-1:0]  r_offset;
   logic [SIZE-1:0]  r_howmany;
   logic [SIZE-1:0]  r_start;
   logic [SIZE-1:0]  r_rd_addr;
   logic [SIZE-1:0]  r_rd_cnt;
   logic [CHW-1:0]   r_ch;
   logic             r_inflight;
   logic [CHW-1:0]   r_q_ch;
   logic             r_q_last;
   logic [c_SKW-1:0] r_sk0, r_sk1;
   logic [1:0]       r_occ;
   logic             r_trig_lost;

   logic             w_wr_en, w_rd_en, w_done, w_read_entry;
   logic             w_pop, w_room, w_ch_end, w_last_rd, w_busy;
   logic [2:0]       w_pending;
   logic [SIZE-1:0]  w_start;
   logic [c_SKW-1:0] w_push;

   // Samples held or already requested after this cycle's pop; a new read is
   // only legal if its data is guaranteed a free slot when it arrives.
   assign w_pop     = (r_occ != 2'd0) && bus.dout_ready_i;
   assign w_pending = 3'(r_occ) + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_room    = (w_pending < 3'd2);

   assign w_ch_end  = (r_rd_cnt == r_howmany - SIZE'(1));
   assign w_last_rd = w_ch_end && (r_ch == c_LAST_CH);

   // The write in the exit cycle is still happening, so stop = addr + 1.
   // Leaving ACQ directly (posttrig 0) uses the offset being latched now.
   assign w_start = (r_wr_addr + SIZE'(1)) -
                    ((r_state == S_ACQ) ? offset_i : r_offset);

   assign w_push  = {r_q_last, r_q_ch, bus.mem_q_i};
   assign w_busy  = (r_state == S_POST) || (r_state == S_READ) ||
                    (r_state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      w_done       = 1'b0;
      w_read_entry = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (arm_i) w_state_nxt = S_ACQ;
         end
         S_ACQ: begin
            w_wr_en = 1'b1;
            if (trig_i) begin
               if (posttrig_i == '0) begin
                  w_state_nxt  = S_READ;
                  w_read_entry = 1'b1;
               end else begin
                  w_state_nxt  = S_POST;
               end
            end else if (!arm_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_POST: begin
            w_wr_en = 1'b1;
            if (r_post_cnt == SIZE'(1)) begin
               w_state_nxt  = S_READ;
               w_read_entry = 1'b1;
            end
         end
         S_READ: begin
            if (r_howmany == '0) begin
               w_state_nxt = S_DRAIN;
            end else if (w_room) begin
               w_rd_en = 1'b1;
               if (w_last_rd) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_occ == 2'd0) && !r_inflight) begin
               w_done      = 1'b1;
               w_state_nxt = arm_i ? S_ACQ : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_addr   <= '0;
         r_post_cnt  <= '0;
         r_offset    <= '0;
         r_howmany   <= '0;
         r_start     <= '0;
         r_rd_addr   <= '0;
         r_rd_cnt    <= '0;
         r_ch        <= '0;
         r_inflight  <= 1'b0;
         r_q_ch      <= '0;
         r_q_last    <= 1'b0;
         r_sk0       <= '0;
         r_sk1       <= '0;
         r_occ       <= 2'd0;
         r_trig_lost <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_addr <= r_wr_addr + SIZE'(1);

         if ((r_state == S_ACQ) && trig_i) begin
            r_offset   <= offset_i;
            r_howmany  <= howmany_i;
            r_post_cnt <= posttrig_i;
         end else if (r_state == S_POST) begin
            r_post_cnt <= r_post_cnt - SIZE'(1);
         end

         // Each channel restarts at the same window start address.
         if (w_read_entry) begin
            r_start   <= w_start;
            r_rd_addr <= w_start;
            r_rd_cnt  <= '0;
            r_ch      <= '0;
         end else if (w_rd_en) begin
            if (w_ch_end) begin
               r_rd_cnt  <= '0;
               r_rd_addr <= r_start;
               if (!w_last_rd) r_ch <= r_ch + CHW'(1);
            end else begin
               r_rd_cnt  <= r_rd_cnt + SIZE'(1);
               r_rd_addr <= r_rd_addr + SIZE'(1);
            end
         end

         r_inflight <= w_rd_en;
         r_q_ch     <= r_ch;
         r_q_last   <= w_last_rd;

         // Head slot r_sk0 always drives the stream so it stays put on stall.
         case ({r_inflight, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_sk0 <= w_push;
               else               r_sk1 <= w_push;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_sk0 <= r_sk1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_sk0 <= w_push;
               end else begin
                  r_sk0 <= r_sk1;
                  r_sk1 <= w_push;
               end
            end
            default: ;
         endcase

         r_trig_lost <= trig_i && w_busy;
      end
   end

   assign bus.wr_en_o      = w_wr_en;
   assign bus.wr_addr_o    = r_wr_addr;
   assign bus.rd_en_o      = w_rd_en;
   assign bus.rd_addr_o    = r_rd_addr;
   assign bus.ch_sel_o     = r_ch;
   assign bus.dout_o       = r_sk0[DW-1:0];
   assign bus.dout_ch_o    = r_sk0[DW+CHW-1:DW];
   assign bus.dout_last_o  = r_sk0[c_SKW-1];
   assign bus.dout_valid_o = (r_occ != 2'd0);
   assign busy_o           = w_busy;
   assign done_o           = w_done;
   assign trig_lost_o      = r_trig_lost;

endmodule
`default_nettype wire

// File: tb/tb_ring_ro_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_ro_sched
//  Description : Directed bench for ring_ro_sched. A table of events
//                (trigger address, window settings, backpressure, extra
//                trigger) is run in a loop; reset and mid-readout reset are
//                hand-written sequences. RAM data is a known function of
//                (channel, address) so every output sample is predictable.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ring_ro_sched;
   localparam int SIZE = 8;
   localparam int DW   = 12;
   localparam int NCH  = 4;
   localparam int CHW  = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            arm = 1'b0;
   logic            trig = 1'b0;
   logic [SIZE-1:0] posttrig = '0;
   logic [SIZE-1:0] offset = '0;
   logic [SIZE-1:0] howmany = '0;
   logic            busy, done, trig_lost;
   logic            rdy = 1'b1;
   bit              bp = 1'b0;
   logic [DW-1:0]   mem_q = '0;

   ring_ro_sched_if #(.SIZE(SIZE), .DW(DW), .CHW(CHW)) bus ();

   ring_ro_sched #(.SIZE(SIZE), .DW(DW), .NCH(NCH), .CHW(CHW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm_i       (arm),
      .trig_i      (trig),
      .posttrig_i  (posttrig),
      .offset_i    (offset),
      .howmany_i   (howmany),
      .bus         (bus),
      .busy_o      (busy),
      .done_o      (done),
      .trig_lost_o (trig_lost)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] f(input logic [CHW-1:0] c, input logic [SIZE-1:0] a);
      return {c, 2'b10, a};
   endfunction

   // RAM model: data appears the cycle after the read strobe
   always @(posedge clk) if (bus.rd_en_o) mem_q <= f(bus.ch_sel_o, bus.rd_addr_o);
   assign bus.mem_q_i      = mem_q;
   assign bus.dout_ready_i = rdy;

   initial forever begin
      @(posedge clk); #1;
      rdy = bp ? ~rdy : 1'b1;
   end

   // ---------------- monitor ----------------
   int              cyc = 0;
   int              n_tests = 0, n_fail = 0;
   int              n_pop, n_rd, n_done, n_lost, n_post_wr, max_out, hold_err;
   int              last_pop_cyc, done_cyc;
   logic [SIZE-1:0] last_wr, stop_seen;
   bit              stop_cap, prev_stall;
   logic [14:0]     prev_word, cur_word;
   logic [14:0]     got[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      cur_word = {bus.dout_last_o, bus.dout_ch_o, bus.dout_o};
      if (bus.wr_en_o) begin
         last_wr = bus.wr_addr_o;
         if (busy) n_post_wr++;
      end
      if (busy && !bus.wr_en_o && !stop_cap) begin
         stop_seen = last_wr + 8'd1;
         stop_cap  = 1'b1;
      end
      if (prev_stall && !(bus.dout_valid_o && cur_word == prev_word)) hold_err++;
      prev_stall = bus.dout_valid_o && !bus.dout_ready_i;
      prev_word  = cur_word;
      if (bus.rd_en_o) n_rd++;
      if (bus.dout_valid_o && bus.dout_ready_i) begin
         got.push_back(cur_word);
         n_pop++;
         last_pop_cyc = cyc;
      end
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
      if (done) begin n_done++; done_cyc = cyc; end
      if (trig_lost) n_lost++;
   end

   task automatic clear_mon();
      n_pop = 0; n_rd = 0; n_done = 0; n_lost = 0; n_post_wr = 0;
      max_out = 0; hold_err = 0; last_pop_cyc = -10; done_cyc = -20;
      stop_cap = 1'b0; prev_stall = 1'b0; got.delete();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- event table ----------------
   typedef struct {
      bit [7:0] trig_at;
      bit [7:0] post;
      bit [7:0] off;
      bit [7:0] hm;
      bit       bp;
      bit       extra;
      int       min_cyc;
      bit [7:0] exp_stop;
      bit [7:0] exp_start;
      int       exp_lost;
   } vec_t;

   vec_t vecs[5];

   task automatic start_event(input vec_t v, input int idx);
      bit found;
      clear_mon();
      bp = v.bp; posttrig = v.post; offset = v.off; howmany = v.hm; arm = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (bus.wr_en_o && !busy && bus.wr_addr_o == v.trig_at && c >= v.min_cyc) begin
            found = 1'b1;
            break;
         end
      end
      chk($sformatf("v%0d trig_addr_reached", idx), found, 1);
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
      if (v.extra) begin
         found = 1'b0;
         for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (bus.rd_en_o) begin found = 1'b1; break; end
         end
         chk($sformatf("v%0d read_started", idx), found, 1);
         trig = 1'b1;
         @(posedge clk); #1;
         trig = 1'b0;
      end
   endtask

   task automatic finish_event(input vec_t v, input int idx);
      bit          ok;
      int          n, ch, k;
      logic [14:0] e;
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (n_done > 0) begin ok = 1'b1; break; end
      end
      chk($sformatf("v%0d done_seen", idx), ok, 1);
      repeat (3) begin @(posedge clk); #1; end
      n = NCH * int'(v.hm);
      chk($sformatf("v%0d stop", idx), stop_seen, v.exp_stop);
      chk($sformatf("v%0d post_writes", idx), n_post_wr, v.post);
      chk($sformatf("v%0d rd_count", idx), n_rd, n);
      chk($sformatf("v%0d sample_count", idx), got.size(), n);
      for (int i = 0; i < got.size() && i < n; i++) begin
         ch = i / int'(v.hm);
         k  = i % int'(v.hm);
         e  = {(i == n - 1), 2'(ch), f(2'(ch), 8'(int'(v.exp_start) + k))};
         chk($sformatf("v%0d sample%0d", idx, i), got[i], e);
      end
      chk($sformatf("v%0d done_pulses", idx), n_done, 1);
      if (n > 0) chk($sformatf("v%0d done_after_last", idx), done_cyc, last_pop_cyc + 1);
      chk($sformatf("v%0d trig_lost", idx), n_lost, v.exp_lost);
      chk($sformatf("v%0d buffered_le2", idx), (max_out <= 2), 1);
      chk($sformatf("v%0d hold_stable", idx), hold_err, 0);
      chk($sformatf("v%0d back_to_acq", idx), {busy, bus.wr_en_o}, 2'b01);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_wr"}, {bus.wr_en_o, bus.wr_addr_o}, 0);
      chk({name, "_rd"}, {bus.rd_en_o, bus.rd_addr_o, bus.ch_sel_o}, 0);
      chk({name, "_dout"}, {bus.dout_valid_o, bus.dout_last_o, bus.dout_ch_o, bus.dout_o}, 0);
      chk({name, "_status"}, {busy, done, trig_lost}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{trig_at:8'h2C, post:8'd4, off:8'd10, hm:8'd3, bp:1'b0, extra:1'b0,
                  min_cyc:300, exp_stop:8'h31, exp_start:8'h27, exp_lost:0};
      vecs[1] = '{trig_at:8'hFE, post:8'd1, off:8'd3, hm:8'd4, bp:1'b0, extra:1'b0,
                  min_cyc:0, exp_stop:8'h00, exp_start:8'hFD, exp_lost:0};
      vecs[2] = '{trig_at:8'h40, post:8'd2, off:8'd5, hm:8'd5, bp:1'b1, extra:1'b0,
                  min_cyc:0, exp_stop:8'h43, exp_start:8'h3E, exp_lost:0};
      vecs[3] = '{trig_at:8'h80, post:8'd0, off:8'd7, hm:8'd0, bp:1'b0, extra:1'b0,
                  min_cyc:0, exp_stop:8'h81, exp_start:8'h7A, exp_lost:0};
      vecs[4] = '{trig_at:8'h10, post:8'd3, off:8'd8, hm:8'd2, bp:1'b0, extra:1'b1,
                  min_cyc:0, exp_stop:8'h14, exp_start:8'h0C, exp_lost:1};
      clear_mon();

      // Reset state and idle hold
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_no_write", {bus.wr_en_o, bus.wr_addr_o, busy}, 0);

      for (int i = 0; i < 5; i++) begin
         start_event(vecs[i], i);
         finish_event(vecs[i], i);
      end
      bp = 1'b0;

      // Reset in the middle of a readout
      begin
         vec_t r;
         bit   ok;
         r = '{trig_at:8'h50, post:8'd2, off:8'd20, hm:8'd8, bp:1'b0, extra:1'b0,
               min_cyc:0, exp_stop:8'h53, exp_start:8'h3F, exp_lost:0};
         start_event(r, 9);
         ok = 1'b0;
         for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (n_pop >= 3) begin ok = 1'b1; break; end
         end
         chk("midrst_reading", ok, 1);
         rst_n = 1'b0;
         arm   = 1'b0;
         @(posedge clk); #1;
         chk_all_zero("midrst");
         rst_n = 1'b1;
         clear_mon();
         repeat (40) begin @(posedge clk); #1; end
         chk("midrst_no_done", n_done, 0);
         chk("midrst_idle", {busy, bus.wr_en_o, bus.dout_valid_o}, 0);
      end

      // Re-arm after the abandoned event
      start_event(vecs[0], 10);
      finish_event(vecs[0], 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ring_ro_sched.md
Name: ring_ro_sched

Overview:
- Sequences acquisition and readout of the NCH lockstep ring buffers in the digitizer.
- During acquisition it owns the shared write pointer and write enable.
- On a trigger it runs a post-trigger window, then freezes writes.
- It then reads a window of `howmany` samples from each channel in turn, round-robin from channel 0, onto a single valid/ready output stream with a 2-deep skid buffer.

Parameters:
- SIZE, 8: ring buffer address width; depth is 2^SIZE.
- DW, 12: sample width.
- NCH, 4: number of channels.
- CHW, 2: channel index width; must satisfy 2^CHW >= NCH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- arm_i  in  1  level; enables acquisition.
- trig_i  in  1  trigger, sampled each clk.
- posttrig_i  in  SIZE  samples written after the trigger sample.
- offset_i  in  SIZE  readout start distance behind the stop pointer.
- howmany_i  in  SIZE  samples read per channel; 0 means none.
- wr_en_o  out  1  write strobe to all ring buffers.
- wr_addr_o  out  SIZE  shared write address.
- rd_en_o  out  1  read strobe; RAM data is valid on mem_q_i the next cycle.
- rd_addr_o  out  SIZE  read address.
- ch_sel_o  out  CHW  channel select for the external mem_q_i mux; valid with rd_en_o.
- mem_q_i  in  DW  selected channel read data.
- dout_o  out  DW  output sample.
- dout_ch_o  out  CHW  channel of dout_o.
- dout_valid_o  out  1  output valid.
- dout_ready_i  in  1  output ready.
- dout_last_o  out  1  last sample of the event.
- busy_o  out  1  high in POST, READ or DRAIN.
- done_o  out  1  one-cycle pulse at the end of the event.
- trig_lost_o  out  1  one-cycle pulse when a trigger is ignored.

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - state goes to IDLE; wr_addr_o, rd_addr_o, ch_sel_o and all counters go to 0.
  - The skid buffer and the in-flight flag are flushed.
  - Every output is 0.
  - Reset mid-readout abandons the event; no done_o is generated.
- IDLE:
  - wr_en_o is 0.
  - If arm_i=1, go to ACQ next cycle; wr_addr_o keeps its value.
- ACQ:
  - wr_en_o=1; wr_addr_o increments by 1 each cycle, wrapping modulo 2^SIZE.
  - If arm_i=0 and trig_i=0, go to IDLE.
  - If trig_i=1, go to POST; trig_i has priority over arm_i=0.
  - On the trigger edge, latch offset_i, howmany_i and posttrig_i. The write in the trigger cycle is sample 0.
- POST:
  - Writing continues for exactly posttrig_i more cycles; a down-counter is loaded with the latched posttrig_i.
  - If posttrig_i=0, POST lasts 0 cycles and the FSM goes straight from ACQ to READ.
  - On exit, wr_en_o=0. stop = wr_addr_o, which is the last written address + 1.
  - start = stop - offset, modulo 2^SIZE.
- READ:
  - For ch = 0..NCH-1, issue reads at start, start+1, ... modulo 2^SIZE, `howmany` per channel.
  - ch_sel_o advances when a channel's count is exhausted.
  - If howmany=0, no reads are issued; go to DRAIN.
  - Issue rule: rd_en_o=1 only when (skid occupancy + in-flight read) < 2, counting a pop in the same cycle.
  - mem_q_i is captured into the skid buffer the cycle after rd_en_o, together with its channel and a last tag.
  - With dout_ready_i held at 1, throughput is 1 sample per cycle; the first dout_valid_o appears 2 cycles after the first rd_en_o.
- DRAIN:
  - Wait until the skid buffer is empty and nothing is in flight.
  - Then pulse done_o for one cycle. Next state is ACQ if arm_i=1, else IDLE.
- Output handshake:
  - A sample transfers when dout_valid_o and dout_ready_i are both 1.
  - While dout_ready_i=0, dout_o, dout_ch_o and dout_last_o hold stable.
  - dout_last_o=1 only on the final sample of channel NCH-1.
- trig_i in POST, READ or DRAIN is ignored and produces a trig_lost_o pulse. It is not queued.
- arm_i=0 during POST, READ or DRAIN has no effect until DRAIN completes.
- busy_o=1 in POST, READ and DRAIN.
- Wrap-around:
  - start + k wraps modulo 2^SIZE.
  - If offset < howmany, reads run past stop into stale data. This is allowed and is not flagged.

Test Plan:
- SIZE=8, NCH=4. Arm, run 300 cycles, trigger at wr_addr=0x2C with posttrig=4, offset=10, howmany=3. Required: writes stop after 0x30; stop=0x31; reads 0x27..0x29 for ch0 through ch3; 12 samples; dout_last_o on the 12th; done_o 1 cycle later.
- Wrap case: trigger at wr_addr=0xFE, posttrig=1, offset=3, howmany=4. Required: stop=0x00; each channel reads 0xFD, 0xFE, 0xFF, 0x00.
- Backpressure: dout_ready_i toggles 1/0 every cycle. Required: exact sample order preserved; output held stable while not ready; never more than 2 samples buffered; rd_en_o stalls accordingly.
- howmany=0 with posttrig=0. Required: no rd_en_o; done_o pulses; return to ACQ with arm_i=1.
- Second trig_i pulse during READ. Required: one trig_lost_o pulse; the event completes unchanged.
- rst_n low for 1 cycle in mid-READ. Required: all outputs 0 the next cycle; IDLE; no done_o; re-arm works normally.
